// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: one partial product per clock, start/busy/done handshake.
// Optional EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [2*WIDTH-1:0]  acc;
    logic [2*WIDTH-1:0]  mcand;
    logic [2*WIDTH-1:0]  sum;
    logic [WIDTH-1:0]    mplr;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_next;
    logic                finish;

    // The sum includes this edge's partial product, so the final value can go straight to product.
    always_comb begin
        sum      = acc + (mplr[0] ? mcand : '0);
        cnt_next = cnt + CW'(1);
`ifdef EARLY_TERM_EN
        finish   = (cnt_next == CW'(WIDTH)) || ((mplr >> 1) == '0);
`else
        finish   = (cnt_next == CW'(WIDTH));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // product is only touched on the completing edge, so it never exposes a partial sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, a};
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= sum;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt_next;
                    if (finish) begin
                        product <= sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH 8, 2 and 16; expected products and completion
// cycles are queued at issue and popped by a monitor whenever a unit pulses done.
module tb_seq_multiplier;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_q = 1'b0;
    int          cyc = 0;

    logic        start8 = 1'b0;
    logic        start2 = 1'b0;
    logic        start16 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic [1:0]  a2 = '0;
    logic [1:0]  b2 = '0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        busy8, busy2, busy16;
    logic        done8, done2, done16;
    logic [15:0] prod8;
    logic [3:0]  prod2;
    logic [31:0] prod16;

    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb[3][$];
    int          busy_run[3];
    bit          prev_done[3];
    logic [63:0] prev_p[3];
    int          w2_exp[16] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 4, 6, 0, 3, 6, 9};

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    seq_multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .product(prod2)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .product(prod16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= cyc + 1;
    end

    function automatic int width_of(int u);
        return (u == 0) ? 8 : ((u == 1) ? 2 : 16);
    endfunction

    function automatic logic busy_of(int u);
        return (u == 0) ? busy8 : ((u == 1) ? busy2 : busy16);
    endfunction

    // Cycles spent in RUN for a given multiplier value.
    function automatic int lat_of(int w, logic [63:0] bv);
        int hb = 1;
        for (int i = 0; i < w; i++) begin
            if (bv[i]) hb = i + 1;
        end
`ifdef EARLY_TERM_EN
        return hb;
`else
        return (hb > 0) ? w : w;
`endif
    endfunction

    task automatic check_output(string name, int u, logic [63:0] act, logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s unit%0d at cycle %0d: got 0x%0h, required 0x%0h", name, u, cyc, act, req);
        end
    endtask

    task automatic monitor_unit(int u, logic d, logic bz, logic [63:0] p);
        exp_t e;
        if (rst_q) begin
            check_output("reset_busy", u, 64'(bz), 64'd0);
            check_output("reset_done", u, 64'(d), 64'd0);
            check_output("reset_product", u, p, 64'd0);
            sb[u].delete();
            busy_run[u]  = 0;
            prev_done[u] = 1'b0;
            prev_p[u]    = p;
            return;
        end
        busy_run[u] = bz ? busy_run[u] + 1 : 0;
        if (prev_done[u]) check_output("busy_after_done", u, 64'(bz), 64'd0);
        if (d) begin
            if (sb[u].size() == 0) begin
                check_output("unexpected_done", u, 64'd1, 64'd0);
            end else begin
                e = sb[u].pop_front();
                check_output("product", u, p, e.prod);
                check_output("done_cycle", u, 64'(cyc), 64'(e.cyc));
                check_output("busy_cycles", u, 64'(busy_run[u]), 64'(e.lat + 1));
            end
        end else begin
            check_output("product_hold", u, p, prev_p[u]);
            if (sb[u].size() > 0 && cyc > sb[u][0].cyc) begin
                e = sb[u].pop_front();
                check_output("missing_done", u, 64'd0, 64'd1);
            end
        end
        prev_done[u] = d;
        prev_p[u]    = p;
    endtask

    always @(negedge clk) begin
        monitor_unit(0, done8, busy8, 64'(prod8));
        monitor_unit(1, done2, busy2, 64'(prod2));
        monitor_unit(2, done16, busy16, 64'(prod16));
    end

    // Waits for the unit to be idle, drives one request and queues its expected result.
    task automatic apply_stimulus(int u, logic [63:0] av, logic [63:0] bv, logic [63:0] ex, bit hold);
        int n = 0;
        int l;
        @(negedge clk);
        while (busy_of(u) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("idle_wait", u, 64'd1, 64'd0);
        case (u)
            0: begin a8 = av[7:0]; b8 = bv[7:0]; start8 = 1'b1; end
            1: begin a2 = av[1:0]; b2 = bv[1:0]; start2 = 1'b1; end
            default: begin a16 = av[15:0]; b16 = bv[15:0]; start16 = 1'b1; end
        endcase
        l = lat_of(width_of(u), bv);
        sb[u].push_back('{ex, cyc + 1 + l, l});
        @(negedge clk);
        if (!hold) begin
            case (u)
                0: start8 = 1'b0;
                1: start2 = 1'b0;
                default: start16 = 1'b0;
            endcase
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        apply_stimulus(0, 64'hFF, 64'hFF, 64'hFE01, 1'b0);

        apply_stimulus(0, 64'h0D, 64'h0B, 64'h008F, 1'b0);
        a8 = 8'h00;
        b8 = 8'h00;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;

        apply_stimulus(0, 64'h12, 64'h34, 64'h03A8, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(0, 64'h12, 64'h34, 64'h03A8, 1'b0);

        apply_stimulus(0, 64'h21, 64'h05, 64'h00A5, 1'b0);
        apply_stimulus(0, 64'h37, 64'h00, 64'h0000, 1'b0);
        apply_stimulus(0, 64'h03, 64'h80, 64'h0180, 1'b0);
        apply_stimulus(0, 64'h00, 64'hFF, 64'h0000, 1'b0);

        apply_stimulus(2, 64'hFFFF, 64'h0001, 64'h0000FFFF, 1'b0);
        apply_stimulus(2, 64'h8000, 64'h8000, 64'h40000000, 1'b0);
        apply_stimulus(2, 64'hFFFF, 64'hFFFF, 64'hFFFE0001, 1'b0);

        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1, 64'(i >> 2), 64'(i & 3), 64'(w2_exp[i]), 1'b1);
        end
        start2 = 1'b0;

        n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_output("drain", 0, 64'd1, 64'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
